// File: rtl/conv3x3_mac_pkg.sv
// Shared constants and types for the 3x3 convolution MAC: kernel geometry,
// pipeline depth, weight address map and the per-window control bundle.
package conv3x3_mac_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int TAPS        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIPE_DEPTH  = 4;
  localparam int W_ADDR_W    = 4;
  localparam int SHIFT_W     = 4;

  localparam int ROW_BOT = 0;
  localparam int ROW_MID = 1;
  localparam int ROW_TOP = 2;

  // Weight/tap address: row 2 is the top row of the window.
  function automatic int tap_addr(input int row, input int col);
    return KERNEL_SIZE * row + col;
  endfunction

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
  } ctl_t;

endpackage

// File: rtl/conv3x3_mac_row_sum.sv
// Adds the three sign-extended tap products of one kernel row.
module conv_row_sum
  import conv3x3_mac_pkg::*;
#(
  parameter int ACC_WIDTH = 20
) (
  input  logic signed [ACC_WIDTH-1:0] prod_i [KERNEL_SIZE],
  output logic signed [ACC_WIDTH-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      sum_o = sum_o + prod_i[c];
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 signed convolution MAC: products, row sums, total+bias, then
// round/shift/ReLU/saturate into the output register; one global stall.
module conv3x3_mac
  import conv3x3_mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*WIDTH-1:0]     win2,
  input  logic [3*WIDTH-1:0]     win1,
  input  logic [3*WIDTH-1:0]     win0,
  input  logic                   win_valid,
  output logic                   win_ready,
  input  logic                   w_wen,
  input  logic [W_ADDR_W-1:0]    w_addr,
  input  logic [WIDTH-1:0]       w_data,
  input  logic [ACC_WIDTH-1:0]   bias,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   relu_en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  // Two guard bits: three row sums plus a full-range bias plus the rounding
  // term cannot overflow.
  localparam int TOT_W = ACC_WIDTH + 2;
  localparam logic signed [TOT_W-1:0] SAT_MAX = TOT_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [TOT_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [TOT_W-1:0] sx_tot(input logic signed [ACC_WIDTH-1:0] v);
    return {{(TOT_W - ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sx_acc(input logic [WIDTH-1:0] v);
    return {{(ACC_WIDTH - WIDTH){v[WIDTH-1]}}, v};
  endfunction

  logic adv, accept;

  logic [WIDTH-1:0]            weight_q [TAPS];
  logic [WIDTH-1:0]            pix      [TAPS];
  logic signed [ACC_WIDTH-1:0] prod_d   [TAPS];
  logic signed [ACC_WIDTH-1:0] prod_q   [TAPS];
  logic signed [ACC_WIDTH-1:0] row_d    [KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0] row_q    [KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0] bias1_q, bias2_q;
  logic signed [TOT_W-1:0]     tot_d, tot_q;
  ctl_t                        ctl1_q, ctl2_q, ctl3_q;
  logic [PIPE_DEPTH-2:0]       sv_q;
  logic [WIDTH-1:0]            out_data_d, out_data_q;
  logic                        out_valid_q;

  logic signed [TOT_W-1:0] rnd, rounded, shifted, clamped;

  assign adv       = !out_valid_q || out_ready;
  assign accept    = win_valid && adv;
  assign win_ready = adv;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (|sv_q) || out_valid_q;

  always_comb begin
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      pix[tap_addr(ROW_TOP, c)] = win2[c*WIDTH +: WIDTH];
      pix[tap_addr(ROW_MID, c)] = win1[c*WIDTH +: WIDTH];
      pix[tap_addr(ROW_BOT, c)] = win0[c*WIDTH +: WIDTH];
    end
  end

  // Low ACC_WIDTH bits of the product of two sign-extended operands are the
  // exact signed product, which always fits.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = sx_acc(pix[i]) * sx_acc(weight_q[i]);
    end
  end

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
    logic signed [ACC_WIDTH-1:0] row_prod [KERNEL_SIZE];
    for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_tap
      assign row_prod[c] = prod_q[KERNEL_SIZE*r + c];
    end
    conv_row_sum #(.ACC_WIDTH(ACC_WIDTH)) u_row_sum (
      .prod_i (row_prod),
      .sum_o  (row_d[r])
    );
  end

  assign tot_d = sx_tot(row_q[0]) + sx_tot(row_q[1]) + sx_tot(row_q[2]) + sx_tot(bias2_q);

  always_comb begin
    rnd = '0;
    if (ctl3_q.shift != '0) rnd[ctl3_q.shift - 1'b1] = 1'b1;
    rounded = tot_q + rnd;
    shifted = rounded >>> ctl3_q.shift;
    clamped = (ctl3_q.relu_en && shifted[TOT_W-1]) ? '0 : shifted;
    if (clamped > SAT_MAX)      out_data_d = SAT_MAX[WIDTH-1:0];
    else if (clamped < SAT_MIN) out_data_d = SAT_MIN[WIDTH-1:0];
    else                        out_data_d = clamped[WIDTH-1:0];
  end

  // A window accepted in a write cycle still sees the old weight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) weight_q[i] <= '0;
    end else if (w_wen && (w_addr < W_ADDR_W'(TAPS))) begin
      weight_q[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      for (int r = 0; r < KERNEL_SIZE; r++) row_q[r] <= '0;
      bias1_q     <= '0;
      bias2_q     <= '0;
      tot_q       <= '0;
      ctl1_q      <= '0;
      ctl2_q      <= '0;
      ctl3_q      <= '0;
      sv_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      prod_q      <= prod_d;
      bias1_q     <= bias;
      ctl1_q      <= '{shift: shift, relu_en: relu_en};
      row_q       <= row_d;
      bias2_q     <= bias1_q;
      ctl2_q      <= ctl1_q;
      tot_q       <= tot_d;
      ctl3_q      <= ctl2_q;
      sv_q        <= {sv_q[PIPE_DEPTH-3:0], accept};
      out_valid_q <= sv_q[PIPE_DEPTH-2];
      if (sv_q[PIPE_DEPTH-2]) out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized and directed bench for conv3x3_mac against an arithmetic
// reference model with an in-order scoreboard.
module tb_conv3x3_mac;

  localparam int W  = 8;
  localparam int AW = 2 * W + 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*W-1:0]  win2, win1, win0;
  logic            win_valid, win_ready;
  logic            w_wen;
  logic [3:0]      w_addr;
  logic [W-1:0]    w_data;
  logic [AW-1:0]   bias;
  logic [3:0]      shift;
  logic            relu_en;
  logic [W-1:0]    out_data;
  logic            out_valid, out_ready, busy;

  always #5 clk = ~clk;

  conv3x3_mac #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .win2(win2), .win1(win1), .win0(win0),
    .win_valid(win_valid), .win_ready(win_ready),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data),
    .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  int       n_cmp = 0;
  int       n_err = 0;
  int       wm [9];
  longint   exp_q [$];
  int       acc_q [$];
  longint   out_hist [$];
  int       cyc = 0;
  bit       lat_chk = 1'b0;
  bit       prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Convolution as the plain sum of pixel*weight, then round, ReLU, clamp.
  function automatic longint model(input logic [3*W-1:0] r2, input logic [3*W-1:0] r1,
                                   input logic [3*W-1:0] r0, input longint b,
                                   input int sh, input bit relu);
    logic [3*W-1:0] rv [3];
    longint s;
    longint p;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    s = b;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = longint'($signed(rv[r][c*W +: W]));
        s += p * longint'(wm[3*r + c]);
      end
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic step(output bit acc);
    longint e;
    int     a;
    @(negedge clk);
    cyc++;
    acc = win_valid && win_ready;
    if (prev_stall) begin
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_data", longint'(out_data), longint'(prev_data));
    end
    if (out_valid && !out_ready) chk("win_ready_stall", longint'(win_ready), 0);
    if (acc) begin
      exp_q.push_back(model(win2, win1, win0, longint'($signed(bias)), int'(shift), relu_en));
      acc_q.push_back(cyc);
    end
    if (w_wen && w_addr < 4'd9) wm[w_addr] = int'($signed(w_data));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", longint'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("out_data", longint'($signed(out_data)), e);
        if (lat_chk) chk("latency", longint'(cyc - a), 4);
        out_hist.push_back(longint'($signed(out_data)));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int px [9], input int b, input int sh, input bit relu);
    logic [3*W-1:0] rv [3];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) rv[r][c*W +: W] = W'(px[3*r + c]);
    win2 = rv[2]; win1 = rv[1]; win0 = rv[0];
    bias = AW'(b); shift = 4'(sh); relu_en = relu;
  endtask

  task automatic send(input int px [9], input int b, input int sh, input bit relu);
    bit acc;
    int k;
    set_win(px, b, sh, relu);
    win_valid = 1'b1;
    acc = 1'b0;
    for (k = 0; k < 50 && !acc; k++) step(acc);
    if (!acc) chk("accept_timeout", longint'(win_ready), 1);
    win_valid = 1'b0;
  endtask

  task automatic write_w(input int addr, input int data);
    bit acc;
    w_wen = 1'b1; w_addr = 4'(addr); w_data = W'(data);
    step(acc);
    w_wen = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) step(acc);
    chk("drain_left", longint'(exp_q.size()), 0);
  endtask

  function automatic longint last_out(input int back);
    if (out_hist.size() <= back) return -9999;
    return out_hist[out_hist.size() - 1 - back];
  endfunction

  initial begin
    bit acc;
    int px [9];
    int pxs [10][9];
    int t, i, n0, nacc;

    rst = 1'b0; win_valid = 1'b0; w_wen = 1'b0; w_addr = '0; w_data = '0;
    win2 = '0; win1 = '0; win0 = '0; bias = '0; shift = '0; relu_en = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_win_ready", longint'(win_ready), 1);
    chk("rst_out_data", longint'(out_data), 0);
    rst = 1'b1;

    // Weights are zero out of reset.
    px = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    lat_chk = 1'b1;
    send(px, 0, 0, 1'b0);
    drain();
    chk("rst_weights_zero", last_out(0), 0);

    for (int k = 0; k < 9; k++) write_w(k, 1);
    send(px, 0, 0, 1'b0);
    drain();
    chk("sum_1_to_9", last_out(0), 45);

    for (int k = 0; k < 9; k++) write_w(k, 127);
    px = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    send(px, 0, 0, 1'b0);
    px = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    send(px, 0, 0, 1'b0);
    drain();
    chk("sat_pos", last_out(1), 127);
    chk("sat_neg", last_out(0), -128);

    for (int k = 0; k < 9; k++) write_w(k, (k == 4) ? 1 : 0);
    px = '{-5, -5, -5, -5, -5, -5, -5, -5, -5};
    send(px, 0, 0, 1'b1);
    send(px, 0, 0, 1'b0);
    px = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    send(px, 0, 1, 1'b0);
    drain();
    chk("relu_on", last_out(2), 0);
    chk("relu_off", last_out(1), -5);
    chk("round_half", last_out(0), 2);

    // Back-to-back with a three-cycle output stall.
    lat_chk = 1'b0;
    for (int k = 0; k < 9; k++) write_w(k, int'($urandom_range(0, 255)) - 128);
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < 9; k++) pxs[j][k] = int'($urandom_range(0, 255)) - 128;
    n0 = out_hist.size();
    i = 0;
    for (t = 0; t < 60 && (i < 10 || exp_q.size() > 0); t++) begin
      out_ready = !(t >= 6 && t <= 8);
      if (i < 10) begin
        set_win(pxs[i], int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 6)), 1'b0);
        win_valid = 1'b1;
      end else begin
        win_valid = 1'b0;
      end
      step(acc);
      if (acc) i++;
    end
    win_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("stall_count", longint'(out_hist.size() - n0), 10);

    // Weight write coinciding with acceptance of window A.
    lat_chk = 1'b1;
    for (int k = 0; k < 9; k++) write_w(k, 1);
    px = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    set_win(px, 0, 0, 1'b0);
    win_valid = 1'b1;
    w_wen = 1'b1; w_addr = 4'd4; w_data = 8'd5;
    step(acc);
    chk("wen_a_accepted", longint'(acc), 1);
    w_wen = 1'b0;
    step(acc);
    chk("wen_b_accepted", longint'(acc), 1);
    win_valid = 1'b0;
    drain();
    chk("wen_a_old", last_out(1), 9);
    chk("wen_b_new", last_out(0), 13);

    // Random traffic with random backpressure and weight writes.
    lat_chk = 1'b0;
    nacc = 0;
    for (t = 0; t < 3000 && nacc < 150; t++) begin
      for (int k = 0; k < 9; k++) px[k] = int'($urandom_range(0, 255)) - 128;
      set_win(px, int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW - 1)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      win_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      w_wen     = ($urandom_range(0, 9) < 3);
      w_addr    = 4'($urandom_range(0, 15));
      w_data    = W'($urandom_range(0, 255));
      step(acc);
      if (acc) nacc++;
    end
    win_valid = 1'b0; w_wen = 1'b0; out_ready = 1'b1;
    chk("rand_accepted", longint'(nacc), 150);
    drain();

    // Reset with three windows in flight.
    for (int k = 0; k < 9; k++) write_w(k, 3);
    px = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    set_win(px, 0, 0, 1'b0);
    win_valid = 1'b1;
    repeat (3) step(acc);
    win_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_win_ready", longint'(win_ready), 1);
    exp_q.delete();
    acc_q.delete();
    prev_stall = 1'b0;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) step(acc);
    chk("post_rst_busy", longint'(busy), 0);
    lat_chk = 1'b1;
    send(px, 0, 0, 1'b0);
    drain();
    chk("post_rst_weights", last_out(0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
